// File: rtl/apb_mem_slave_pkg.sv
// Shared types and helpers for the APB memory slave.
package apb_pkg;

    // Bus phases as seen by the slave.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Largest wait-state count the 4-bit wait counter can hold.
    localparam int MAX_WAIT_STATES = 15;

    // Number of byte-offset bits below the word index for a given data width.
    function automatic int addr_lsb(input int data_width);
        return (data_width <= 8) ? 0 : $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and an
// asynchronous read port.
module apb_mem_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6
) (
    input  logic                    clk,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH/8-1:0] byte_we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write: lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (byte_we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 memory slave: wait states, byte strobes and an
// out-of-range error response.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int NB       = DATA_WIDTH / 8;
    localparam int BANK_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH may equal 2^IDX_W, so the compare needs one extra bit.
    localparam logic [IDX_W:0] DEPTH_L   = DEPTH[IDX_W:0];
    localparam logic [3:0]     WAIT_INIT = WAIT_STATES[3:0];

    apb_state_e       state, state_n, phase;
    logic [3:0]       wait_cnt, cnt_n;
    logic [IDX_W-1:0] idx;
    logic             err;
    logic [NB-1:0]    byte_we;
    logic [DATA_WIDTH-1:0] rdata;

    assign idx = paddr[ADDR_WIDTH-1:ADDR_LSB];

    // Byte-offset bits are deliberately ignored.
    if (ADDR_LSB > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^paddr[ADDR_LSB-1:0];
    end

    assign err     = ({1'b0, idx} >= DEPTH_L);
    assign pready  = (state == ACCESS) & psel & penable & (wait_cnt == 4'd0);
    assign pslverr = pready & err;
    assign prdata  = (pready & ~pwrite & ~err) ? rdata : '0;

    // Writes commit only on an in-range completion, never on a reset edge.
    assign byte_we = (pready & pwrite & ~err & ~preset) ? pstrb : '0;

    // Current bus phase. SETUP is the cycle with psel & !penable, decoded
    // straight from the bus so the very next cycle is already ACCESS and a
    // zero-wait transfer completes in two cycles. penable seen while idle
    // leaves the registered IDLE in place, so it is ignored.
    always_comb begin
        if (!psel)         phase = IDLE;
        else if (!penable) phase = SETUP;
        else               phase = state;
    end

    // Next-state and wait-counter update.
    always_comb begin
        state_n = state;
        cnt_n   = wait_cnt;
        case (phase)
            SETUP: begin
                state_n = ACCESS;
                cnt_n   = WAIT_INIT;
            end
            ACCESS: begin
                if (wait_cnt != 4'd0) cnt_n = wait_cnt - 4'd1;
                else                  state_n = IDLE;
            end
            default: state_n = IDLE;  // includes psel dropped mid-ACCESS
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= cnt_n;
        end
    end

    apb_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (BANK_AW)
    ) u_bank (
        .clk     (pclk),
        .addr    (idx[BANK_AW-1:0]),
        .byte_we (byte_we),
        .wdata   (pwdata),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states), shared clock,
// randomized traffic checked against an array model.
module tb_apb_mem_slave;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        pclk;
    logic [1:0]  preset, psel, penable, pwrite;
    logic [9:0]  paddr  [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pstrb  [2];
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [31:0] prdata0, prdata1;

    exp_t        q0[$], q1[$];
    logic [31:0] ref_mem [2][64];
    int          n_cmp = 0, n_bad = 0;

    apb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));

    apb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) dut3 (
        .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready1), .prdata(prdata1), .pslverr(pslverr1));

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ws(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    // Monitor: pops an expectation on every pready pulse; outside
    // completions the response outputs must stay zero.
    task automatic mon(input int u);
        logic rdy, err;
        logic [31:0] rd;
        exp_t e;
        bit empty;
        rdy   = (u == 0) ? pready0  : pready1;
        err   = (u == 0) ? pslverr0 : pslverr1;
        rd    = (u == 0) ? prdata0  : prdata1;
        empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (rdy === 1'b1) begin
            if (empty) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pready u%0d: got pready=1 expected no completion at %0t", u, $time);
            end else begin
                e = (u == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("resp_pslverr u%0d", u), {31'b0, err}, {31'b0, e.err});
                chk($sformatf("resp_prdata u%0d", u), rd, e.data);
            end
        end else begin
            chk($sformatf("idle_pready u%0d", u), {31'b0, rdy}, 32'd0);
            chk($sformatf("idle_prdata u%0d", u), rd, 32'd0);
            chk($sformatf("idle_pslverr u%0d", u), {31'b0, err}, 32'd0);
        end
    endtask

    always @(negedge pclk) begin
        mon(0);
        mon(1);
    end

    // One full transfer, entered and left at posedge+1. Successive calls
    // are back-to-back: the idle values set at the end are overwritten by
    // the next setup in the same time step.
    task automatic xfer(input int u, input bit wr, input logic [9:0] addr,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        logic [7:0] idx;
        int cyc;
        idx   = addr[9:2];
        e.err = (idx >= 8'd64);
        e.data = 32'd0;
        if (wr) begin
            if (!e.err)
                for (int i = 0; i < 4; i++)
                    if (s[i]) ref_mem[u][idx[5:0]][8*i +: 8] = d[8*i +: 8];
        end else if (!e.err) begin
            e.data = ref_mem[u][idx[5:0]];
        end
        if (u == 0) q0.push_back(e); else q1.push_back(e);

        psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr;
        paddr[u] = addr; pwdata[u] = d; pstrb[u] = s;
        @(posedge pclk); #1;
        penable[u] = 1'b1;
        cyc = 2;
        @(negedge pclk);
        while (((u == 0) ? pready0 : pready1) !== 1'b1 && cyc < 40) begin
            @(posedge pclk); #1;
            cyc++;
            @(negedge pclk);
        end
        chk($sformatf("latency u%0d", u), 32'(cyc), 32'(ws(u) + 2));
        @(posedge pclk); #1;
        psel[u] = 1'b0; penable[u] = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        preset = 2'b11; psel = 2'b00; penable = 2'b00; pwrite = 2'b00;
        for (int u = 0; u < 2; u++) begin
            paddr[u] = '0; pwdata[u] = '0; pstrb[u] = '0;
        end

        // Reset state.
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("reset_pready0", {31'b0, pready0}, 32'd0);
        chk("reset_pslverr0", {31'b0, pslverr0}, 32'd0);
        chk("reset_prdata0", prdata0, 32'd0);
        chk("reset_pready1", {31'b0, pready1}, 32'd0);
        chk("reset_pslverr1", {31'b0, pslverr1}, 32'd0);
        chk("reset_prdata1", prdata1, 32'd0);
        @(posedge pclk); #1;
        preset = 2'b00;

        // Preload every word so later reads compare defined data.
        for (int u = 0; u < 2; u++)
            for (int w = 0; w < 64; w++)
                xfer(u, 1'b1, 10'(w * 4), $urandom, 4'hF);

        // Basic write/read, then byte-strobe merge.
        xfer(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 10'h010, 32'h0, 4'h0);
        xfer(0, 1'b1, 10'h010, 32'h11223344, 4'h5);
        xfer(0, 1'b0, 10'h010, 32'h0, 4'h0);

        // Out of range: error on write and read, aliasing word 0 untouched.
        xfer(0, 1'b1, 10'h100, 32'hA5A5A5A5, 4'hF);
        xfer(0, 1'b0, 10'h100, 32'h0, 4'h0);
        xfer(0, 1'b0, 10'h000, 32'h0, 4'h0);

        // Back-to-back writes then reads.
        xfer(0, 1'b1, 10'h000, 32'h1, 4'hF);
        xfer(0, 1'b1, 10'h004, 32'h2, 4'hF);
        xfer(0, 1'b0, 10'h000, 32'h0, 4'h0);
        xfer(0, 1'b0, 10'h004, 32'h0, 4'h0);

        // Wait states, zero-strobe write, last word, ignored low address bits.
        xfer(1, 1'b0, 10'h010, 32'h0, 4'h0);
        xfer(1, 1'b1, 10'h020, 32'hCAFEF00D, 4'h0);
        xfer(1, 1'b0, 10'h020, 32'h0, 4'h0);
        xfer(1, 1'b1, 10'h0FF, 32'h5A5A0001, 4'hA);
        xfer(1, 1'b0, 10'h0FC, 32'h0, 4'h0);

        // Abort: psel drops after one ACCESS cycle, no memory update.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 10'h00C; pwdata[1] = 32'h0BAD0BAD; pstrb[1] = 4'hF;
        @(posedge pclk); #1; penable[1] = 1'b1;
        @(posedge pclk); #1; psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge pclk); #1;
        xfer(1, 1'b0, 10'h00C, 32'h0, 4'h0);

        // Reset during the 2nd wait cycle of a write to 0x8.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 10'h008; pwdata[1] = 32'hFEEDFACE; pstrb[1] = 4'hF;
        @(posedge pclk); #1; penable[1] = 1'b1;
        @(posedge pclk); #1; preset[1] = 1'b1;
        @(posedge pclk); #1; preset[1] = 1'b0;
        @(negedge pclk);
        chk("midreset_pready", {31'b0, pready1}, 32'd0);
        chk("midreset_prdata", prdata1, 32'd0);
        // penable still high while IDLE must be ignored for another cycle.
        @(posedge pclk); #1; psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge pclk); #1;
        xfer(1, 1'b0, 10'h008, 32'h0, 4'h0);

        // Randomized mix; some addresses fall past the last word.
        for (int i = 0; i < 120; i++) begin
            d = $urandom;
            xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                 10'($urandom_range(0, 'h13F)), d, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
        end

        repeat (3) @(posedge pclk);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
